// File: rtl/cache_nway.sv
// N-way set-associative cache array: true-LRU age counters per set, registered lookup
// outputs and a multi-cycle invalidate-all sweep. Define CACHE_STATS_EN for hit/miss counters.
module cache_nway #(
    parameter int ADDR_BITS  = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 32,
    parameter int LINE_WORDS = 4,
    localparam int WAY_BITS  = $clog2(WAYS),
    localparam int SET_BITS  = $clog2(SETS),
    localparam int WORD_BITS = $clog2(LINE_WORDS),
    localparam int TAG_BITS  = ADDR_BITS - SET_BITS - WORD_BITS - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 load,
    input  logic                 store,
    input  logic                 edit,
    input  logic                 invalid,
    input  logic                 flush_all,
    input  logic [2:0]           u_b_h_w,
    input  logic [31:0]          din,
    output logic                 hit,
    output logic [WAY_BITS-1:0]  hit_way,
    output logic [31:0]          dout,
    output logic                 valid,
    output logic                 dirty,
    output logic [TAG_BITS-1:0]  tag,
    output logic                 busy
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);
    typedef enum logic {IDLE, SWEEP} state_t;

    localparam int IDX_BITS = SET_BITS + WAY_BITS + WORD_BITS;

    logic [31:0]         data_mem [SETS*WAYS*LINE_WORDS];
    logic [TAG_BITS-1:0] tag_mem  [SETS*WAYS];
    logic [WAYS-1:0]     valid_q  [SETS];
    logic [WAYS-1:0]     dirty_q  [SETS];
    logic [WAY_BITS-1:0] age_q    [SETS][WAYS];

    state_t              state_q, state_d;
    logic [SET_BITS-1:0] ptr_q, ptr_d;

    logic                hit_q;
    logic [WAY_BITS-1:0] hit_way_q;
    logic [31:0]         dout_q;
    logic                vvalid_q, vdirty_q;
    logic [TAG_BITS-1:0] vtag_q;

    logic [TAG_BITS-1:0]  a_tag;
    logic [SET_BITS-1:0]  a_set;
    logic [WORD_BITS-1:0] a_word;
    assign a_tag  = addr[ADDR_BITS-1 -: TAG_BITS];
    assign a_set  = addr[2+WORD_BITS +: SET_BITS];
    assign a_word = addr[2 +: WORD_BITS];

    logic [WAYS-1:0]     hit_vec, vict_vec;
    logic [31:0]         way_word [WAYS];
    logic [WAY_BITS-1:0] hit_idx, vict_idx, hit_age;
    logic                any_hit;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        assign hit_vec[gi]  = valid_q[a_set][gi] && (tag_mem[{a_set, WAY_BITS'(gi)}] == a_tag);
        assign vict_vec[gi] = (age_q[a_set][gi] == WAY_BITS'(WAYS - 1));
        assign way_word[gi] = data_mem[{a_set, WAY_BITS'(gi), a_word}];
    end

    always_comb begin
        hit_idx  = '0;
        vict_idx = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w])  hit_idx  = WAY_BITS'(w);
            if (vict_vec[w]) vict_idx = WAY_BITS'(w);
        end
        any_hit = |hit_vec;
        hit_age = age_q[a_set][hit_idx];
    end

    function automatic logic [31:0] lane_read(input logic [31:0] w, input logic [1:0] bo,
                                              input logic [2:0] t);
        logic [15:0] h;
        logic [7:0]  b;
        h = bo[1] ? w[31:16] : w[15:0];
        b = bo[0] ? h[15:8] : h[7:0];
        if (t[1])      return w;
        else if (t[0]) return t[2] ? {16'h0, h} : {{16{h[15]}}, h};
        else           return t[2] ? {24'h0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [31:0] d,
                                               input logic [1:0] bo, input logic [2:0] t);
        logic [31:0] m;
        m = w;
        if (t[1])      m = d;
        else if (t[0]) m[{bo[1], 4'b0000} +: 16] = d[15:0];
        else           m[{bo, 3'b000} +: 8] = d[7:0];
        return m;
    endfunction

    logic                idle, act_flush, act_inv, act_store, act_edit, act_load, touch;
    logic                mem_we, inv_now;
    logic [IDX_BITS-1:0] mem_waddr;
    logic [31:0]         mem_wdata;
    logic [SET_BITS-1:0] inv_set;

    // Only the highest-priority write action wins; the read path always evaluates.
    always_comb begin
        idle      = (state_q == IDLE);
        act_flush = idle && flush_all;
        act_inv   = idle && !flush_all && invalid;
        act_store = idle && !flush_all && !invalid && store;
        act_edit  = idle && !flush_all && !invalid && !store && edit;
        act_load  = idle && !flush_all && !invalid && !store && !edit && load;
        touch     = (act_edit || act_load) && any_hit;
        mem_we    = act_store || (act_edit && any_hit);
        mem_waddr = {a_set, act_store ? vict_idx : hit_idx, a_word};
        mem_wdata = act_store ? din : lane_merge(way_word[hit_idx], din, addr[1:0], u_b_h_w);
        inv_now   = !idle || act_inv;
        inv_set   = idle ? a_set : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we)    data_mem[mem_waddr] <= mem_wdata;
        if (act_store) tag_mem[{a_set, vict_idx}] <= a_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_BITS'(w);
            end
        end else if (inv_now) begin
            valid_q[inv_set] <= '0;
            dirty_q[inv_set] <= '0;
            for (int w = 0; w < WAYS; w++) age_q[inv_set][w] <= WAY_BITS'(w);
        end else if (act_store) begin
            valid_q[a_set][vict_idx] <= 1'b1;
            dirty_q[a_set][vict_idx] <= 1'b0;
        end else if (touch) begin
            if (act_edit) dirty_q[a_set][hit_idx] <= 1'b1;
            for (int w = 0; w < WAYS; w++)
                if (age_q[a_set][w] < hit_age) age_q[a_set][w] <= age_q[a_set][w] + 1'b1;
            age_q[a_set][hit_idx] <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: if (act_flush) begin
                state_d = SWEEP;
                ptr_d   = '0;
            end
            SWEEP: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == SET_BITS'(SETS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // With load low the victim word is presented so the controller can drain a write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q     <= 1'b0;
            hit_way_q <= '0;
            dout_q    <= '0;
            vvalid_q  <= 1'b0;
            vdirty_q  <= 1'b0;
            vtag_q    <= '0;
        end else if (idle) begin
            hit_q     <= any_hit;
            hit_way_q <= any_hit ? hit_idx : '0;
            vvalid_q  <= valid_q[a_set][vict_idx];
            vdirty_q  <= dirty_q[a_set][vict_idx];
            vtag_q    <= tag_mem[{a_set, vict_idx}];
            if (!load)        dout_q <= way_word[vict_idx];
            else if (any_hit) dout_q <= lane_read(way_word[hit_idx], addr[1:0], u_b_h_w);
        end else begin
            hit_q     <= 1'b0;
            hit_way_q <= '0;
        end
    end

    assign hit     = hit_q;
    assign hit_way = hit_way_q;
    assign dout    = dout_q;
    assign valid   = vvalid_q;
    assign dirty   = vdirty_q;
    assign tag     = vtag_q;
    assign busy    = (state_q == SWEEP);

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || act_flush) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (act_edit || act_load) begin
            if (any_hit && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (!any_hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: doc/cache_nway.md
Name: cache_nway

Overview:
- Parametrised N-way set-associative cache array; successor to the fixed 2-way/32-set array.
- Generalised in ways, sets and line length.
- Uses true-LRU age counters per set instead of a single recent bit.
- Adds a multi-cycle invalidate-all sweep FSM with a busy flag.
- Sits between the CPU-side load/store unit and the cache controller FSM, which sequences miss refills and write-backs through the store and dout paths.

Parameters:
- ADDR_BITS, 32, address width.
- WAYS, 4, associativity; power of 2, at least 2. WAY_BITS = log2(WAYS).
- SETS, 32, number of sets; power of 2. SET_BITS = log2(SETS).
- LINE_WORDS, 4, 32-bit words per line; power of 2. WORD_BITS = log2(LINE_WORDS).
- TAG_BITS, ADDR_BITS-SET_BITS-WORD_BITS-2, derived tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDR_BITS  address = {tag, set, word, byte[1:0]}.
- load  in  1  CPU read; refreshes LRU on hit.
- store  in  1  memory-to-cache fill of one word into the victim way.
- edit  in  1  CPU write on hit; sets dirty.
- invalid  in  1  invalidate all ways of the addressed set.
- flush_all  in  1  start the invalidate-all sweep.
- u_b_h_w  in  3  access type: [1] word, [0] half, [2] unsigned (RV32I LB/LH/LW/LBU/LHU).
- din  in  32  write/fill data.
- hit  out  1  registered hit.
- hit_way  out  WAY_BITS  registered hitting way; 0 on miss.
- dout  out  32  registered read data.
- valid  out  1  registered valid bit of the victim line.
- dirty  out  1  registered dirty bit of the victim line.
- tag  out  TAG_BITS  registered tag of the victim line, for write-back address formation.
- busy  out  1  sweep in progress.

Behaviour:
- Reset: all valid=0, dirty=0, age[s][w]=w. Outputs hit=0, hit_way=0, dout=0, valid=0, dirty=0, tag=0, busy=0. Tag and data RAM contents are not reset.
- Reset mid-sweep aborts the sweep; the FSM returns to IDLE the next cycle.
- Lookup (combinational): hit_w = valid[s][w] & tag[s][w]==addr_tag. At most one way hits. Victim = the way with age==WAYS-1.
- Outputs are registered; 1-cycle latency. Every cycle in IDLE they present hit, hit_way, and the victim's valid/dirty/tag for the current addr.
- Read path, load=1 and hit: dout = selected word/half/byte, sign- or zero-extended per u_b_h_w. Half selected by addr[1]; byte selected by addr[1:0].
- Read path, load=1 and miss: dout holds its previous value.
- Read path, load=0: dout = victim line word at addr word offset (write-back drain). LRU is not touched.
- LRU update (load hit or edit hit, hit way h with age a): every way in the set with age < a increments; age[s][h] = 0. Ages remain a permutation of 0..WAYS-1.
- edit on hit: merge din into the word at the lane (word / half by addr[1] / byte by addr[1:0]); dirty=1; LRU update. edit on miss: no state change.
- store: write din at addr word offset of the victim way; valid=1, dirty=0, tag=addr_tag. Ages are not changed, so the victim stays stable across a multi-word line fill.
- invalid: clear valid and dirty of all ways in set s; reset ages to age[s][w]=w.
- Priority, same cycle: flush_all > invalid > store > edit > load. Only the highest-priority write action takes effect; the read/dout path always evaluates.
- FSM IDLE: flush_all=1 -> SWEEP with ptr=0 and busy=1 from the next cycle.
- FSM SWEEP: each cycle invalidate set ptr (same effect as invalid); ptr++. At ptr==SETS-1, return to IDLE; busy=0 in the following cycle. The sweep takes exactly SETS cycles.
- While busy: load/store/edit/invalid/flush_all are ignored. hit=0; valid, dirty, tag and dout hold their values.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0], both reset to 0.
  - Counted on non-busy cycles where load|edit is the winning action: increment hit_cnt on hit, miss_cnt on miss.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both are cleared when the sweep starts.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Test Plan:
- Defaults. Reset, then load addr=0x0000_0010 -> next cycle hit=0, valid=0, victim way 3 (age 3).
- Defaults. Fill 4 words with store at 0x0000_1230..0x0000_123C, din=0x11,0x22,0x33,0x44; then load LW at 0x0000_1238 -> hit=1, hit_way=3, dout=0x0000_0033.
- Defaults. Word 0x0000_80F0 resident at 0x0000_1230. edit SB din=0xAB at 0x0000_1231, then LB at 0x0000_1231 -> dout=0xFFFF_FFAB. LBU -> 0x0000_00AB. Victim is not way 3; way 3 dirty=1.
- LRU. Fill 4 distinct tags in set 3 and touch them in order w0, w1, w2, w3, then load a 5th tag -> victim way 0. Load w0 hit -> victim becomes way 1.
- Sweep. Assert flush_all with SETS=32 -> busy=1 for exactly 32 cycles; loads ignored during busy. Afterwards load any previously resident address -> hit=0, valid=0.
- CACHE_STATS_EN. 3 load hits, 2 load misses, 1 edit miss -> hit_cnt=3, miss_cnt=3. flush_all -> both read 0.
